// File: rtl/map_render_ctrl.sv
// Tile-map renderer pipeline: a tile fetch on the left edge of each 8-pixel tile, a sprite ROM lookup, and a colour register.
// The tile-map RAM port is shared with game-logic writes, and a pixel read always takes the port first.
module map_render_ctrl #(
  parameter int          MAP_X0   = 208,
  parameter int          MAP_Y0   = 116,
  parameter int          MAP_COLS = 28,
  parameter int          MAP_ROWS = 31,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [9:0]  PIX_X,
  input  logic [9:0]  PIX_Y,
  input  logic        PIX_VALID,
  output logic [9:0]  MAP_ADDR,
  output logic        MAP_RD_EN,
  output logic        MAP_WE,
  output logic [6:0]  MAP_WDATA,
  input  logic [6:0]  MAP_RDATA,
  output logic [4:0]  GRID_SELECT,
  output logic [1:0]  ROTATE_SELECT,
  output logic [2:0]  X_INDEX,
  output logic [2:0]  Y_INDEX,
  input  logic [11:0] SPRITE_COLOR,
  input  logic        WR_REQ,
  input  logic [9:0]  WR_ADDR,
  input  logic [6:0]  WR_DATA,
  output logic        WR_ACK,
  output logic [11:0] OUT_COLOR,
  output logic        OUT_VALID
);

  localparam logic [9:0] X_LO    = 10'(MAP_X0);
  localparam logic [9:0] X_HI    = 10'(MAP_X0 + 8 * MAP_COLS);
  localparam logic [9:0] Y_LO    = 10'(MAP_Y0);
  localparam logic [9:0] Y_HI    = 10'(MAP_Y0 + 8 * MAP_ROWS);
  localparam logic [9:0] COLS_W  = 10'(MAP_COLS);
  localparam logic [9:0] N_TILES = 10'(MAP_COLS * MAP_ROWS);

  logic        in_map_s, fetch_s, grant_s;
  logic [9:0]  dx_s, dy_s, tile_addr_s;

  logic        in_map1_q, in_map1_d;
  logic        fetch1_q, fetch1_d;
  logic        pv1_q, pv1_d;
  logic [2:0]  xi_q, xi_d;
  logic [2:0]  yi_q, yi_d;
  logic [6:0]  cache_q, cache_d;
  logic        cache_valid_q, cache_valid_d;
  logic [11:0] out_color_q, out_color_d;
  logic        out_valid_q, out_valid_d;

  // Stage 0: map hit test, tile address and RAM port arbitration.
  always_comb begin
    in_map_s    = PIX_VALID && (PIX_X >= X_LO) && (PIX_X < X_HI) &&
                  (PIX_Y >= Y_LO) && (PIX_Y < Y_HI);
    dx_s        = PIX_X - X_LO;
    dy_s        = PIX_Y - Y_LO;
    tile_addr_s = ({3'd0, dy_s[9:3]} * COLS_W) + {3'd0, dx_s[9:3]};
    fetch_s     = in_map_s && ((dx_s[2:0] == 3'd0) || !cache_valid_q);
    grant_s     = WR_REQ && !fetch_s;
  end

  // RAM port drive; these are combinational, so reset gates them to zero explicitly.
  always_comb begin
    MAP_RD_EN = 1'b0;
    MAP_WE    = 1'b0;
    MAP_WDATA = 7'd0;
    MAP_ADDR  = 10'd0;
    WR_ACK    = 1'b0;
    if (!RST_N) begin
      MAP_RD_EN = 1'b0;
    end else if (fetch_s) begin
      MAP_RD_EN = 1'b1;
      MAP_ADDR  = tile_addr_s;
    end else if (grant_s) begin
      WR_ACK    = 1'b1;
      MAP_WE    = (WR_ADDR < N_TILES);
      MAP_ADDR  = WR_ADDR;
      MAP_WDATA = WR_DATA;
    end else begin
      MAP_ADDR  = 10'd0;
    end
  end

  // Next-state for the stage registers; on a fetch cycle the RAM data bypasses the cache.
  always_comb begin
    in_map1_d     = in_map_s;
    fetch1_d      = fetch_s;
    pv1_d         = PIX_VALID;
    xi_d          = dx_s[2:0];
    yi_d          = dy_s[2:0];
    cache_valid_d = in_map_s;
    cache_d       = fetch1_q ? MAP_RDATA : cache_q;
    out_color_d   = in_map1_q ? SPRITE_COLOR : BG_COLOR;
    out_valid_d   = pv1_q;
  end

  assign GRID_SELECT   = cache_d[6:2];
  assign ROTATE_SELECT = cache_d[1:0];
  assign X_INDEX       = xi_q;
  assign Y_INDEX       = yi_q;
  assign OUT_COLOR     = out_color_q;
  assign OUT_VALID     = out_valid_q;

  // Pipeline, cache and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      in_map1_q     <= 1'b0;
      fetch1_q      <= 1'b0;
      pv1_q         <= 1'b0;
      xi_q          <= 3'd0;
      yi_q          <= 3'd0;
      cache_q       <= 7'd0;
      cache_valid_q <= 1'b0;
      out_color_q   <= 12'd0;
      out_valid_q   <= 1'b0;
    end else begin
      in_map1_q     <= in_map1_d;
      fetch1_q      <= fetch1_d;
      pv1_q         <= pv1_d;
      xi_q          <= xi_d;
      yi_q          <= yi_d;
      cache_q       <= cache_d;
      cache_valid_q <= cache_valid_d;
      out_color_q   <= out_color_d;
      out_valid_q   <= out_valid_d;
    end
  end

endmodule
